// File: rtl/led_frame_scheduler.sv
// Strand refresh sequencer: realigns the WS2812B driver, streams pixels from a synchronous-read RAM and holds the latch gap.
// Define LED_FRAME_DOUBLE_BUFFER_EN to add front/back buffer selection (swap_req / buf_sel_out).
`timescale 1ns/1ps
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 20,
    parameter int RD_LATENCY   = 2,
    parameter int LATCH_CYCLES = 8000,
    localparam int LedW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    localparam int AddrW       = LedW + 1
`else
    localparam int AddrW       = LedW
`endif
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_start,
    input  logic             clear_err,
    input  logic [LedW-1:0]  led_request,
    input  logic             request_valid,
    output logic             rd_en,
    output logic [AddrW-1:0] rd_addr,
    input  logic [23:0]      rd_data,
    output logic [7:0]       green_out,
    output logic [7:0]       red_out,
    output logic [7:0]       blue_out,
    output logic             color_valid,
    output logic             force_reset,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       err_out,
`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    input  logic             swap_req,
    output logic             buf_sel_out,
`endif
    output logic [1:0]       state_dbg
);

    localparam int LatchW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    // All strobes (frame_start, request_valid, rd_en, color_valid, force_reset, frame_done)
    // are single-cycle valid pulses with no ready/backpressure: a pulse is consumed the cycle it is high.
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_LATCH} state_t;

    state_t            state_q, state_d;
    logic [LedW:0]     idx_q, idx_d;
    logic [LatchW-1:0] latch_q, latch_d;
    logic [2:0]        fetch_q, fetch_d;
    logic [23:0]       color_q, color_d;
    logic              cv_q, cv_d;
    logic [1:0]        err_q, err_d;
    logic [1:0]        err_set;
    logic              issue_rd;
    logic [LedW-1:0]   rd_idx;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        latch_d     = latch_q;
        fetch_d     = fetch_q;
        color_d     = color_q;
        cv_d        = 1'b0;
        err_set     = 2'b00;
        issue_rd    = 1'b0;
        rd_idx      = '0;
        force_reset = 1'b0;
        frame_done  = 1'b0;
        if (frame_start && state_q != S_IDLE) err_set[1] = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    force_reset = 1'b1;
                    issue_rd    = 1'b1;
                    idx_d       = '0;
                    fetch_d     = '0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (request_valid) err_set[0] = 1'b1;
                if (fetch_q == 3'(RD_LATENCY - 1)) begin
                    color_d = rd_data;
                    cv_d    = 1'b1;
                    idx_d   = idx_q + (LedW + 1)'(1);
                    state_d = S_WAIT;
                end else begin
                    fetch_d = fetch_q + 3'd1;
                end
            end
            S_WAIT: begin
                // Once every pixel is out, a driver wrap request is simply dropped.
                if (idx_q == (LedW + 1)'(NUM_LEDS)) begin
                    latch_d = '0;
                    state_d = S_LATCH;
                end else if (request_valid) begin
                    issue_rd = 1'b1;
                    rd_idx   = idx_q[LedW-1:0];
                    fetch_d  = '0;
                    state_d  = S_FETCH;
                    if ({1'b0, led_request} != idx_q) err_set[0] = 1'b1;
                end
            end
            S_LATCH: begin
                if (latch_q == LatchW'(LATCH_CYCLES - 1)) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    latch_d = latch_q + LatchW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = (clear_err ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            latch_q <= '0;
            fetch_q <= '0;
            color_q <= '0;
            cv_q    <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            fetch_q <= fetch_d;
            color_q <= color_d;
            cv_q    <= cv_d;
            err_q   <= err_d;
        end
    end

`ifdef LED_FRAME_DOUBLE_BUFFER_EN
    logic swap_pend_q, buf_sel_q;

    // The swap lands on the frame_done edge, so the front buffer is stable for the whole frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            swap_pend_q <= 1'b0;
            buf_sel_q   <= 1'b0;
        end else begin
            if (frame_done && swap_pend_q) begin
                buf_sel_q   <= ~buf_sel_q;
                swap_pend_q <= swap_req;
            end else if (swap_req) begin
                swap_pend_q <= 1'b1;
            end
        end
    end

    assign buf_sel_out = buf_sel_q;
    assign rd_addr     = issue_rd ? {buf_sel_q, rd_idx} : '0;
`else
    assign rd_addr     = issue_rd ? rd_idx : '0;
`endif

    assign rd_en       = issue_rd;
    assign green_out   = color_q[23:16];
    assign red_out     = color_q[15:8];
    assign blue_out    = color_q[7:0];
    assign color_valid = cv_q;
    assign busy        = (state_q != S_IDLE);
    assign err_out     = err_q;
    assign state_dbg   = state_q;

endmodule
